// File: rtl/mips_instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_instr_encoder                                                         |
// | Packs MIPS instruction fields into 32-bit words with byte addresses for    |
// | instruction-memory loading. Optional macro MIPS_ENC_ADDI_EN enables addi.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module mips_instr_encoder #(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   kind,
    input  logic [4:0]                   rs,
    input  logic [4:0]                   rt,
    input  logic [4:0]                   rd,
    input  logic [4:0]                   shamt,
    input  logic [5:0]                   funct,
    input  logic [15:0]                  immediate,
    input  logic [25:0]                  jump_address,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_word,
    output logic [31:0]                  out_addr,
    output logic                         err_invalid,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int                   c_CNT_W   = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0]   c_DEPTH   = c_CNT_W'(DEPTH);

    localparam logic [0:0]           c_S_LOAD  = 1'b0;
    localparam logic [0:0]           c_S_FULL  = 1'b1;

    localparam logic [2:0]           c_K_R     = 3'd0;
    localparam logic [2:0]           c_K_LW    = 3'd1;
    localparam logic [2:0]           c_K_SW    = 3'd2;
    localparam logic [2:0]           c_K_BEQ   = 3'd3;
    localparam logic [2:0]           c_K_J     = 3'd4;
`ifdef MIPS_ENC_ADDI_EN
    localparam logic [2:0]           c_K_ADDI  = 3'd5;
`endif

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [31:0]         r_wr_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  w_count_inc;
    logic [31:0]         w_word;
    logic                w_kind_ok;
    logic                w_accept;

    assign w_accept    = in_valid && in_ready;
    assign w_count_inc = r_count + 1'b1;
    assign count       = r_count;

    always_comb begin
        w_word    = 32'h0;
        w_kind_ok = 1'b0;
        case (kind)
            c_K_R: begin
                w_word    = {6'b000000, rs, rt, rd, shamt, funct};
                w_kind_ok = 1'b1;
            end
            c_K_LW: begin
                w_word    = {6'b100011, rs, rt, immediate};
                w_kind_ok = 1'b1;
            end
            c_K_SW: begin
                w_word    = {6'b101011, rs, rt, immediate};
                w_kind_ok = 1'b1;
            end
            c_K_BEQ: begin
                w_word    = {6'b000100, rs, rt, immediate};
                w_kind_ok = 1'b1;
            end
            c_K_J: begin
                w_word    = {6'b000010, jump_address};
                w_kind_ok = 1'b1;
            end
`ifdef MIPS_ENC_ADDI_EN
            c_K_ADDI: begin
                w_word    = {6'b001000, rs, rt, immediate};
                w_kind_ok = 1'b1;
            end
`endif
            default: begin
                w_word    = 32'h0;
                w_kind_ok = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_LOAD: begin
                if (!clear && w_accept && w_kind_ok && (w_count_inc == c_DEPTH)) begin
                    w_state_nxt = c_S_FULL;
                end
            end
            c_S_FULL: begin
                if (clear) begin
                    w_state_nxt = c_S_LOAD;
                end
            end
            default: w_state_nxt = c_S_LOAD;
        endcase
    end

    // Output logic
    always_comb begin
        full     = (r_state == c_S_FULL);
        in_ready = (r_state == c_S_LOAD) && !clear && (!out_valid || out_ready);
    end

    // Datapath: a consumed word is replaced by a same-cycle accept for full throughput
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_word    <= 32'h0;
            out_addr    <= BASE_ADDR;
            err_invalid <= 1'b0;
            r_wr_ptr    <= BASE_ADDR;
            r_count     <= '0;
        end else if (clear) begin
            out_valid   <= 1'b0;
            err_invalid <= 1'b0;
            r_wr_ptr    <= BASE_ADDR;
            r_count     <= '0;
        end else begin
            err_invalid <= 1'b0;
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_kind_ok) begin
                    out_valid <= 1'b1;
                    out_word  <= w_word;
                    out_addr  <= r_wr_ptr;
                    r_wr_ptr  <= r_wr_ptr + 32'd4;
                    r_count   <= w_count_inc;
                end else begin
                    err_invalid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mips_instr_encoder                                                      |
// | Directed and random stimulus against a field-packing reference model.      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_mips_instr_encoder;

    localparam int          DEPTH     = 4;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  kind;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] immediate;
    logic [25:0] jump_address;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic        err_invalid;
    logic        full;
    logic [2:0]  count;

    mips_instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .kind(kind),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .immediate(immediate), .jump_address(jump_address),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_addr(out_addr),
        .err_invalid(err_invalid), .full(full), .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: pending word plus number of words accepted since restart
    bit          m_valid;
    logic [31:0] m_word;
    logic [31:0] m_addr;
    int          m_count;
    bit          m_err;

    function automatic bit kind_valid(input logic [2:0] k);
`ifdef MIPS_ENC_ADDI_EN
        return (k <= 3'd5);
`else
        return (k <= 3'd4);
`endif
    endfunction

    function automatic logic [31:0] encode(input logic [2:0] k);
        logic [5:0] op;
        case (k)
            3'd1: op = 6'd35;
            3'd2: op = 6'd43;
            3'd3: op = 6'd4;
            3'd5: op = 6'd8;
            default: op = 6'd0;
        endcase
        if (k == 3'd0) return {6'd0, rs, rt, rd, shamt, funct};
        if (k == 3'd4) return {6'd2, jump_address};
        return {op, rs, rt, immediate};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, act, exp);
    endtask

    task automatic model_reset();
        m_valid = 0; m_word = 32'h0; m_addr = BASE_ADDR; m_count = 0; m_err = 0;
    endtask

    task automatic drive(input logic v, input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
                         input logic [15:0] im, input logic [25:0] ja, input logic ordy, input logic clr);
        in_valid = v; kind = k; rs = s; rt = t; rd = d; shamt = sh; funct = fn;
        immediate = im; jump_address = ja; out_ready = ordy; clear = clr;
    endtask

    // One clock: check in_ready, advance model on the edge, check outputs on the falling edge
    task automatic step();
        bit exp_rdy;
        bit acc;
        #1;
        exp_rdy = (m_count < DEPTH) && !clear && (!m_valid || out_ready);
        chk("in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
        acc = in_valid && exp_rdy;
        @(posedge clk);
        if (clear) begin
            m_valid = 0; m_count = 0; m_err = 0;
        end else begin
            m_err = 0;
            if (out_ready) m_valid = 0;
            if (acc) begin
                if (kind_valid(kind)) begin
                    m_valid = 1;
                    m_word  = encode(kind);
                    m_addr  = BASE_ADDR + 32'(4 * m_count);
                    m_count++;
                end else begin
                    m_err = 1;
                end
            end
        end
        @(negedge clk);
        chk("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
        chk("err_invalid", {31'h0, err_invalid}, {31'h0, m_err});
        chk("full", {31'h0, full}, {31'h0, (m_count == DEPTH)});
        chk("count", {29'h0, count}, 32'(m_count));
        if (m_valid) begin
            chk("out_word", out_word, m_word);
            chk("out_addr", out_addr, m_addr);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_addr", out_addr, BASE_ADDR);
        chk("rst_out_word", out_word, 32'h0);
        chk("rst_count", {29'h0, count}, 32'h0);
        chk("rst_full", {31'h0, full}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        drive(1, 3'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0, 26'h0, 1, 0);
        step();
        chk("add_word", out_word, 32'h012A4020);
        chk("add_addr", out_addr, 32'h0);

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step();

        drive(1, 3'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'h0, 16'h4, 26'h0, 1, 0);
        step();
        chk("lw_word", out_word, 32'h8D280004);
        chk("lw_addr", out_addr, 32'h0);
        kind = 3'd2;
        step();
        chk("sw_word", out_word, 32'hAD280004);
        chk("sw_addr", out_addr, 32'h4);

        drive(1, 3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0100000, 1, 0);
        step();
        chk("j_word", out_word, 32'h08100000);

        drive(1, 3'd3, 5'd9, 5'd10, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0, 0, 0);
        repeat (3) step();
        chk("hold_word", out_word, 32'h08100000);
        chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
        out_ready = 1'b1;
        step();
        chk("beq_word", out_word, 32'h112AFFFF);
        chk("last_addr", out_addr, 32'hC);
        chk("full_set", {31'h0, full}, 32'h1);

        drive(1, 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 0, 0);
        step();
        out_ready = 1'b1; in_valid = 1'b0;
        step();
        clear = 1'b1;
        step();
        chk("clear_count", {29'h0, count}, 32'h0);

        drive(1, 3'd7, 5'd1, 5'd2, 5'd3, 5'd0, 6'h0, 16'h0, 26'h0, 1, 0);
        step();
        chk("bad_err", {31'h0, err_invalid}, 32'h1);
        in_valid = 1'b0;
        step();
        chk("bad_err_pulse", {31'h0, err_invalid}, 32'h0);

        drive(1, 3'd5, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h5, 26'h0, 1, 0);
        step();
`ifdef MIPS_ENC_ADDI_EN
        chk("addi_word", out_word, 32'h20080005);
        chk("addi_addr", out_addr, 32'h0);
`else
        chk("addi_err", {31'h0, err_invalid}, 32'h1);
`endif

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom),
                  5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
            step();
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step();
        drive(1, 3'd0, 5'd4, 5'd5, 5'd6, 5'd2, 6'h00, 16'h0, 26'h0, 0, 0);
        step();
        chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'h0, out_valid}, 32'h0);
        chk("async_addr", out_addr, BASE_ADDR);
        chk("async_count", {29'h0, count}, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 3'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0, 26'h0, 1, 0);
        step();
        chk("post_rst_addr", out_addr, BASE_ADDR);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
Converse of the instruction decoder. It takes instruction fields (kind, registers, immediate, jump target) over a valid/ready handshake and packs them into a 32-bit MIPS machine word. It emits each word with a byte address for loading instruction memory. It sits between the bench or program-loader logic and the IF-stage instruction memory write port, and tracks how many words have been loaded.

Parameters:
DEPTH, 16, number of instruction words in the target memory; the block enters FULL after DEPTH accepted words
BASE_ADDR, 32'h0000_0000, byte address of the first emitted word

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous restart: pointer to BASE_ADDR, count to 0, drop pending output
in_valid  input  1  field bundle valid
in_ready  output  1  block can accept a bundle this cycle
kind  input  3  0=R-type, 1=lw, 2=sw, 3=beq, 4=j, 5=addi (only with the optional feature), others invalid
rs  input  5  source register
rt  input  5  target register
rd  input  5  destination register (R-type only)
shamt  input  5  shift amount (R-type only)
funct  input  6  function code (R-type only)
immediate  input  16  I-type immediate / branch offset
jump_address  input  26  J-type word target
out_valid  output  1  encoded word valid
out_ready  input  1  consumer takes word
out_word  output  32  encoded instruction
out_addr  output  32  byte address of out_word
err_invalid  output  1  one-cycle pulse: invalid kind rejected
full  output  1  DEPTH words accepted
count  output  $clog2(DEPTH+1)  words accepted since reset/clear

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_word=0, out_addr=BASE_ADDR, err_invalid=0, full=0, count=0, internal wr_ptr=BASE_ADDR, state=LOAD. Reset is honoured mid-transfer; the pending word is lost.
- States: LOAD, FULL. LOAD->FULL when an accept makes count==DEPTH. FULL->LOAD only on clear. clear in LOAD also restarts pointer and count.
- in_ready = (state==LOAD) && !clear && (!out_valid || out_ready).
- Accept = in_valid && in_ready. A valid kind gives 1-cycle latency: the next edge loads out_word, sets out_addr=wr_ptr and out_valid=1, and does wr_ptr+=4 and count+=1.
- Encoding:
  - R: {6'b000000, rs, rt, rd, shamt, funct}
  - lw: {6'b100011, rs, rt, immediate}
  - sw: {6'b101011, rs, rt, immediate}
  - beq: {6'b000100, rs, rt, immediate}
  - j: {6'b000010, jump_address}
  - Unused fields for a kind are ignored.
- Invalid kind on accept: err_invalid=1 for exactly one cycle, no output, wr_ptr and count unchanged.
- out_valid clears when out_ready=1 and no new accept occurs in the same cycle. If out_ready and an accept happen in the same cycle, the output is replaced back-to-back, giving full throughput.
- If out_valid=1 and out_ready=0, the output holds stable and in_ready=0.
- The final (DEPTH-th) word is still presented and must be drained. full=1 whenever state==FULL.
- clear has priority over accept in the same cycle: out_valid=0, wr_ptr=BASE_ADDR, count=0, full=0, no err pulse.
- wr_ptr is 32-bit with natural wrap; no wrap can occur before FULL for sane parameters.

Optional Feature:
MIPS_ENC_ADDI_EN. When defined, kind 5 is valid and encodes {6'b001000, rs, rt, immediate}. When undefined, kind 5 is treated as invalid (err_invalid pulse, nothing emitted).

Test Plan:
- Reset, then R add: rs=9, rt=10, rd=8, shamt=0, funct=0x20 -> after 1 cycle out_word=0x012A4020, out_addr=0x0, count=1.
- lw rs=9, rt=8, imm=4, then sw with the same fields, out_ready=1 -> 0x8D280004 at addr 0x0, then 0xAD280004 at addr 0x4 on consecutive cycles.
- j jump_address=26'h0100000 -> 0x08100000; beq rs=9, rt=10, imm=0xFFFF -> 0x112AFFFF.
- out_ready=0 for 3 cycles -> out_word held, in_ready=0. Then kind=7 -> err_invalid pulse, count unchanged; with the macro, kind=5 rs=0, rt=8, imm=5 -> 0x20080005.
- DEPTH=4: send 4 words -> full=1, in_ready=0, last word at addr 0xC. Then clear -> count=0, next word at addr 0x0.
- Assert rst_n low while out_valid=1 -> out_valid drops immediately (asynchronously), pointer returns to BASE_ADDR.
